// File: rtl/lt24_arb_pkg.sv
// Shared types, widths and helpers for the LT24 pixel-write arbiter.
// Consumed by lt24_arb_picker and lt24_pixel_arbiter.
package lt24_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int LT24_X_W   = 8;
    localparam int LT24_Y_W   = 9;
    localparam int LT24_PIX_W = 16;

    // Increment that sticks at max_value instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] value, input logic [15:0] max_value);
        logic [15:0] result;
        if (value >= max_value) begin
            result = max_value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/lt24_arb_picker.sv
// Combinational one-hot winner selection for the pixel arbiter.
// ARB_ROUND_ROBIN_EN: search starts after the last winner; otherwise lowest index wins.
module lt24_arb_picker
    import lt24_arb_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]         req_i,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
`endif
    output logic [NUM_REQ-1:0]         win_o
);

`ifdef ARB_ROUND_ROBIN_EN
    // Rotated search: first requester found at or after ptr+1 wins
    always_comb begin : pick_rr
        int   start_idx;
        int   idx;
        logic found;
        win_o     = '0;
        found     = 1'b0;
        start_idx = (int'(ptr_i) + 1) % NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx        = (start_idx + i) % NUM_REQ;
            win_o[idx] = req_i[idx] && !found;
            found      = found || req_i[idx];
        end
    end
`else
    // Priority encoder: lowest requesting index wins
    always_comb begin : pick_fixed
        logic found;
        win_o = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_o[i] = req_i[i] && !found;
            found    = found || req_i[i];
        end
    end
`endif

endmodule

// File: rtl/lt24_pixel_arbiter.sv
// Burst arbiter sharing the LT24Display pixel port between several renderers,
// clipping off-screen pixels. ARB_ROUND_ROBIN_EN selects round-robin arbitration.
module lt24_pixel_arbiter
    import lt24_arb_pkg::*;
#(
    parameter int NUM_REQ       = 3,
    parameter int WIDTH         = 240,
    parameter int HEIGHT        = 320,
    parameter int STALL_TIMEOUT = 1023
) (
    input  logic                           clock,
    input  logic                           resetApp,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_last,
    input  logic [LT24_X_W*NUM_REQ-1:0]    req_x,
    input  logic [LT24_Y_W*NUM_REQ-1:0]    req_y,
    input  logic [LT24_PIX_W*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             grant,
    output logic [LT24_X_W-1:0]            xAddr,
    output logic [LT24_Y_W-1:0]            yAddr,
    output logic [LT24_PIX_W-1:0]          pixelData,
    output logic                           pixelWrite,
    input  logic                           pixelReady,
    output logic [15:0]                    drop_count,
    output logic [7:0]                     abort_count
);

    localparam bit STALL_EN = (STALL_TIMEOUT != 0);
    localparam int STALL_W  = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT + 1) : 1;
    localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(STALL_TIMEOUT);

    arb_state_e               state_q;
    logic [NUM_REQ-1:0]       grant_q;
    logic [STALL_W-1:0]       stall_q;
    logic [7:0]               abort_q;
    logic [LT24_X_W-1:0]      x_q;
    logic [LT24_Y_W-1:0]      y_q;
    logic [LT24_PIX_W-1:0]    data_q;
    logic                     pix_wr_q;
    logic [15:0]              drop_q;

    logic [NUM_REQ-1:0]       win_s;
    logic                     sel_valid_s;
    logic                     sel_last_s;
    logic [LT24_X_W-1:0]      sel_x_s;
    logic [LT24_Y_W-1:0]      sel_y_s;
    logic [LT24_PIX_W-1:0]    sel_data_s;
    logic                     out_free_s;
    logic                     xfer_s;
    logic                     on_screen_s;
    logic                     consume_s;
    logic                     stall_hit_s;
    logic [STALL_W-1:0]       stall_inc_s;
    logic [15:0]              drop_d;
    logic [7:0]               abort_d;

`ifdef ARB_ROUND_ROBIN_EN
    localparam int PTR_W = $clog2(NUM_REQ);
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
`endif

    lt24_arb_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req_i (req_valid),
`ifdef ARB_ROUND_ROBIN_EN
        .ptr_i (ptr_q),
`endif
        .win_o (win_s)
    );

    // AND-OR mux of the granted requester onto the select bus; grant_q is one-hot or zero
    always_comb begin
        sel_valid_s = 1'b0;
        sel_last_s  = 1'b0;
        sel_x_s     = '0;
        sel_y_s     = '0;
        sel_data_s  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_valid_s = sel_valid_s | (grant_q[i] & req_valid[i]);
            sel_last_s  = sel_last_s  | (grant_q[i] & req_last[i]);
            sel_x_s     = sel_x_s    | ({LT24_X_W{grant_q[i]}}   & req_x[LT24_X_W*i +: LT24_X_W]);
            sel_y_s     = sel_y_s    | ({LT24_Y_W{grant_q[i]}}   & req_y[LT24_Y_W*i +: LT24_Y_W]);
            sel_data_s  = sel_data_s | ({LT24_PIX_W{grant_q[i]}} & req_data[LT24_PIX_W*i +: LT24_PIX_W]);
        end
    end

    assign out_free_s  = !pix_wr_q || pixelReady;
    assign xfer_s      = sel_valid_s && out_free_s;
    assign on_screen_s = (int'(sel_x_s) < WIDTH) && (int'(sel_y_s) < HEIGHT);
    assign consume_s   = pix_wr_q && pixelReady;
    assign stall_inc_s = stall_q + STALL_W'(1);
    assign stall_hit_s = STALL_EN && !sel_valid_s && (stall_inc_s == STALL_LIM);
    assign drop_d      = sat_inc(drop_q, 16'hFFFF);
    assign abort_d     = 8'(sat_inc({8'd0, abort_q}, 16'h00FF));

    // Arbitration FSM with stall watchdog; grant only changes between bursts
    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp) begin
            state_q <= IDLE;
            grant_q <= '0;
            stall_q <= '0;
            abort_q <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    stall_q <= '0;
                    if (|req_valid) begin
                        grant_q <= win_s;
                        state_q <= BURST;
                    end else begin
                        grant_q <= '0;
                        state_q <= IDLE;
                    end
                end
                BURST: begin
                    if (xfer_s && sel_last_s) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        stall_q <= '0;
                    end else if (stall_hit_s) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        stall_q <= '0;
                        abort_q <= abort_d;
                    end else if (sel_valid_s || !STALL_EN) begin
                        stall_q <= '0;
                    end else begin
                        stall_q <= stall_inc_s;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    stall_q <= '0;
                end
            endcase
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Index of this cycle's winner, used to advance the round-robin pointer
    always_comb begin
        ptr_d = ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            ptr_d = win_s[i] ? PTR_W'(i) : ptr_d;
        end
    end

    // Pointer remembers the most recent winner
    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp) begin
            ptr_q <= PTR_W'(NUM_REQ - 1);
        end else if ((state_q == IDLE) && (|req_valid)) begin
            ptr_q <= ptr_d;
        end else begin
            ptr_q <= ptr_q;
        end
    end
`endif

    // Display output register and off-screen drop counter
    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp) begin
            x_q      <= '0;
            y_q      <= '0;
            data_q   <= '0;
            pix_wr_q <= 1'b0;
            drop_q   <= 16'd0;
        end else begin
            if (xfer_s && on_screen_s) begin
                x_q      <= sel_x_s;
                y_q      <= sel_y_s;
                data_q   <= sel_data_s;
                pix_wr_q <= 1'b1;
            end else if (consume_s) begin
                pix_wr_q <= 1'b0;
            end else begin
                pix_wr_q <= pix_wr_q;
            end
            if (xfer_s && !on_screen_s) begin
                drop_q <= drop_d;
            end else begin
                drop_q <= drop_q;
            end
        end
    end

    assign req_ready   = grant_q & {NUM_REQ{out_free_s}};
    assign grant       = grant_q;
    assign xAddr       = x_q;
    assign yAddr       = y_q;
    assign pixelData   = data_q;
    assign pixelWrite  = pix_wr_q;
    assign drop_count  = drop_q;
    assign abort_count = abort_q;

endmodule

// File: tb/tb_lt24_pixel_arbiter.sv
// Self-checking bench for lt24_pixel_arbiter: vector table, directed corner
// sequences and a randomized run against a transaction-level producer/display model.
module tb_lt24_pixel_arbiter;

    localparam int NR = 3;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        resetApp;
    logic [2:0]  req_valid;
    logic [2:0]  req_last;
    logic [23:0] req_x;
    logic [26:0] req_y;
    logic [47:0] req_data;
    logic [2:0]  req_ready;
    logic [2:0]  grant;
    logic [7:0]  xAddr;
    logic [8:0]  yAddr;
    logic [15:0] pixelData;
    logic        pixelWrite;
    logic        pixelReady;
    logic [15:0] drop_count;
    logic [7:0]  abort_count;

    int errors = 0;
    int checks = 0;

    lt24_pixel_arbiter #(
        .NUM_REQ(3), .WIDTH(240), .HEIGHT(320), .STALL_TIMEOUT(8)
    ) dut (
        .clock(clock), .resetApp(resetApp),
        .req_valid(req_valid), .req_last(req_last), .req_x(req_x), .req_y(req_y),
        .req_data(req_data), .req_ready(req_ready), .grant(grant),
        .xAddr(xAddr), .yAddr(yAddr), .pixelData(pixelData), .pixelWrite(pixelWrite),
        .pixelReady(pixelReady), .drop_count(drop_count), .abort_count(abort_count)
    );

    always #10 clock = ~clock;

    typedef struct {
        logic        v;
        logic        l;
        logic [7:0]  x;
        logic [8:0]  y;
        logic        pr;
        logic [2:0]  e_grant;
        logic        e_rdy;
        logic        e_pw;
        logic [7:0]  e_x;
        logic [8:0]  e_y;
        logic [15:0] e_drop;
    } vec_t;

    typedef struct packed {
        logic [7:0]  x;
        logic [8:0]  y;
        logic [15:0] d;
        logic        l;
    } pix_t;

    vec_t        tbl[23];
    pix_t        src_q[3][$];
    pix_t        exp_q[$];
    pix_t        px;
    logic [2:0]  order_q[$];
    logic [2:0]  exp_order[6];
    logic [2:0]  gprev, v_s, eg, er;
    logic        pr_s, t0, t2;
    int          pend0, pend2, busy, owner, mptr, cyc, exp_drops, len;
    int          gap[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int r, input logic v, input logic l, input logic [7:0] x,
                         input logic [8:0] y, input logic [15:0] d);
        req_valid[r]         = v;
        req_last[r]          = l;
        req_x[8*r +: 8]      = x;
        req_y[9*r +: 9]      = y;
        req_data[16*r +: 16] = d;
    endtask

    task automatic idle_all();
        req_valid = '0; req_last = '0; req_x = '0; req_y = '0; req_data = '0;
    endtask

    task automatic next_cycle();
        @(posedge clock); #1;
    endtask

    task automatic do_reset();
        resetApp = 1'b1; idle_all(); pixelReady = 1'b1;
        next_cycle(); next_cycle();
        resetApp = 1'b0;
    endtask

    function automatic int pick(input logic [2:0] v, input int p);
        int s;
        s = RR ? (p + 1) % NR : 0;
        for (int i = 0; i < NR; i++) begin
            if (v[(s + i) % NR]) return (s + i) % NR;
        end
        return 0;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // single burst x=0..3, then backpressure burst x=10..13, then clipping
        tbl[0]  = '{1'b1,1'b0,8'd0,  9'd5,  1'b1, 3'b000,1'b0,1'b0, 8'd0, 9'd0,16'd0};
        tbl[1]  = '{1'b1,1'b0,8'd0,  9'd5,  1'b1, 3'b001,1'b1,1'b0, 8'd0, 9'd0,16'd0};
        tbl[2]  = '{1'b1,1'b0,8'd1,  9'd5,  1'b1, 3'b001,1'b1,1'b1, 8'd0, 9'd5,16'd0};
        tbl[3]  = '{1'b1,1'b0,8'd2,  9'd5,  1'b1, 3'b001,1'b1,1'b1, 8'd1, 9'd5,16'd0};
        tbl[4]  = '{1'b1,1'b1,8'd3,  9'd5,  1'b1, 3'b001,1'b1,1'b1, 8'd2, 9'd5,16'd0};
        tbl[5]  = '{1'b0,1'b0,8'd0,  9'd0,  1'b1, 3'b000,1'b0,1'b1, 8'd3, 9'd5,16'd0};
        tbl[6]  = '{1'b0,1'b0,8'd0,  9'd0,  1'b1, 3'b000,1'b0,1'b0, 8'd0, 9'd0,16'd0};
        tbl[7]  = '{1'b1,1'b0,8'd10, 9'd5,  1'b1, 3'b000,1'b0,1'b0, 8'd0, 9'd0,16'd0};
        tbl[8]  = '{1'b1,1'b0,8'd10, 9'd5,  1'b1, 3'b001,1'b1,1'b0, 8'd0, 9'd0,16'd0};
        tbl[9]  = '{1'b1,1'b0,8'd11, 9'd5,  1'b1, 3'b001,1'b1,1'b1, 8'd10,9'd5,16'd0};
        for (int i = 10; i < 15; i++)
            tbl[i] = '{1'b1,1'b0,8'd12,9'd5, 1'b0, 3'b001,1'b0,1'b1, 8'd11,9'd5,16'd0};
        tbl[15] = '{1'b1,1'b0,8'd12, 9'd5,  1'b1, 3'b001,1'b1,1'b1, 8'd11,9'd5,16'd0};
        tbl[16] = '{1'b1,1'b1,8'd13, 9'd5,  1'b1, 3'b001,1'b1,1'b1, 8'd12,9'd5,16'd0};
        tbl[17] = '{1'b0,1'b0,8'd0,  9'd0,  1'b1, 3'b000,1'b0,1'b1, 8'd13,9'd5,16'd0};
        tbl[18] = '{1'b0,1'b0,8'd0,  9'd0,  1'b1, 3'b000,1'b0,1'b0, 8'd0, 9'd0,16'd0};
        tbl[19] = '{1'b1,1'b0,8'd240,9'd10, 1'b1, 3'b000,1'b0,1'b0, 8'd0, 9'd0,16'd0};
        tbl[20] = '{1'b1,1'b0,8'd240,9'd10, 1'b1, 3'b001,1'b1,1'b0, 8'd0, 9'd0,16'd0};
        tbl[21] = '{1'b1,1'b1,8'd3,  9'd320,1'b1, 3'b001,1'b1,1'b0, 8'd0, 9'd0,16'd1};
        tbl[22] = '{1'b0,1'b0,8'd0,  9'd0,  1'b1, 3'b000,1'b0,1'b0, 8'd0, 9'd0,16'd2};
        if (RR) exp_order = '{3'b001, 3'b100, 3'b001, 3'b100, 3'b001, 3'b100};
        else    exp_order = '{3'b001, 3'b001, 3'b001, 3'b100, 3'b100, 3'b100};

        // reset state
        do_reset();
        #1;
        check("rst grant", grant, 3'b000);
        check("rst ready", req_ready, 3'b000);
        check("rst pixelWrite", pixelWrite, 1'b0);
        check("rst xAddr", xAddr, 8'd0);
        check("rst yAddr", yAddr, 9'd0);
        check("rst pixelData", pixelData, 16'd0);
        check("rst drop", drop_count, 16'd0);
        check("rst abort", abort_count, 8'd0);
        next_cycle();

        // vector table
        for (int i = 0; i < 23; i++) begin
            drive(0, tbl[i].v, tbl[i].l, tbl[i].x, tbl[i].y, 16'h07E0);
            pixelReady = tbl[i].pr;
            #1;
            check($sformatf("tbl%0d grant", i), grant, tbl[i].e_grant);
            check($sformatf("tbl%0d ready", i), req_ready, {2'b00, tbl[i].e_rdy});
            check($sformatf("tbl%0d pixelWrite", i), pixelWrite, tbl[i].e_pw);
            check($sformatf("tbl%0d drop", i), drop_count, tbl[i].e_drop);
            if (tbl[i].e_pw) begin
                check($sformatf("tbl%0d xAddr", i), xAddr, tbl[i].e_x);
                check($sformatf("tbl%0d yAddr", i), yAddr, tbl[i].e_y);
                check($sformatf("tbl%0d data", i), pixelData, 16'h07E0);
            end
            next_cycle();
        end

        // contention between req0 and req2, three one-pixel bursts each
        do_reset();
        pend0 = 3; pend2 = 3; gprev = 3'b000;
        for (int c = 0; c < 60 && (pend0 > 0 || pend2 > 0 || grant != 3'b000); c++) begin
            idle_all();
            if (pend0 > 0) drive(0, 1'b1, 1'b1, 8'(20 + pend0), 9'd40, 16'hF800);
            if (pend2 > 0) drive(2, 1'b1, 1'b1, 8'(30 + pend2), 9'd40, 16'h001F);
            pixelReady = 1'b1;
            #1;
            if (gprev == 3'b000 && grant != 3'b000) order_q.push_back(grant);
            gprev = grant;
            t0 = req_valid[0] && req_ready[0];
            t2 = req_valid[2] && req_ready[2];
            next_cycle();
            if (t0) pend0--;
            if (t2) pend2--;
        end
        check("contention bursts", order_q.size(), 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("contention order%0d", i),
                  (i < order_q.size()) ? order_q[i] : 3'b111, exp_order[i]);
        idle_all(); next_cycle(); next_cycle();

        // stall timeout: req1 sends one pixel then goes quiet, display blocked
        drive(1, 1'b1, 1'b0, 8'd7, 9'd9, 16'hABCD); pixelReady = 1'b0;
        #1; check("to idle grant", grant, 3'b000); next_cycle();
        #1; check("to grant", grant, 3'b010); check("to ready", req_ready, 3'b010); next_cycle();
        drive(1, 1'b0, 1'b0, 8'd0, 9'd0, 16'd0);
        for (int k = 0; k < 8; k++) begin
            #1; check($sformatf("to hold%0d", k), grant, 3'b010); next_cycle();
        end
        #1;
        check("to revoked", grant, 3'b000);
        check("to abort", abort_count, 8'd1);
        check("to pending pw", pixelWrite, 1'b1);
        check("to pending x", xAddr, 8'd7);
        check("to pending data", pixelData, 16'hABCD);
        pixelReady = 1'b1;
        next_cycle();
        #1; check("to drained", pixelWrite, 1'b0); next_cycle();

        // reset mid-burst
        drive(0, 1'b1, 1'b0, 8'd50, 9'd60, 16'h1234);
        next_cycle(); next_cycle();
        #1;
        check("mid pre grant", grant, 3'b001);
        check("mid pre pw", pixelWrite, 1'b1);
        #1; resetApp = 1'b1; idle_all();
        #1;
        check("mid rst grant", grant, 3'b000);
        check("mid rst pw", pixelWrite, 1'b0);
        check("mid rst abort", abort_count, 8'd0);
        check("mid rst drop", drop_count, 16'd0);
        check("mid rst ready", req_ready, 3'b000);
        next_cycle();
        resetApp = 1'b0;
        drive(1, 1'b1, 1'b1, 8'd60, 9'd70, 16'h5555);
        #1; check("post rst idle", grant, 3'b000); next_cycle();
        #1; check("post rst grant", grant, 3'b010); check("post rst ready", req_ready, 3'b010);
        next_cycle(); idle_all();
        #1;
        check("post rst pw", pixelWrite, 1'b1);
        check("post rst x", xAddr, 8'd60);
        check("post rst y", yAddr, 9'd70);
        check("post rst data", pixelData, 16'h5555);

        // randomized traffic against the producer/display model
        do_reset();
        for (int r = 0; r < NR; r++) begin
            gap[r] = 0;
            for (int b = 0; b < 5; b++) begin
                len = $urandom_range(1, 4);
                for (int p = 0; p < len; p++) begin
                    px.x = 8'($urandom_range(0, 255));
                    px.y = 9'($urandom_range(0, 339));
                    px.d = 16'($urandom);
                    px.l = (p == len - 1);
                    src_q[r].push_back(px);
                end
            end
        end
        busy = 0; owner = 0; mptr = NR - 1; cyc = 0; exp_drops = 0;
        while ((src_q[0].size() > 0 || src_q[1].size() > 0 || src_q[2].size() > 0 ||
                busy != 0 || exp_q.size() > 0) && cyc < 3000) begin
            idle_all();
            for (int r = 0; r < NR; r++) begin
                if (src_q[r].size() > 0 && (gap[r] >= 3 || $urandom_range(0, 3) != 0)) begin
                    drive(r, 1'b1, src_q[r][0].l, src_q[r][0].x, src_q[r][0].y, src_q[r][0].d);
                    gap[r] = 0;
                end else if (src_q[r].size() > 0) begin
                    gap[r]++;
                end
            end
            pr_s = ($urandom_range(0, 3) != 0);
            pixelReady = pr_s;
            v_s = req_valid;
            eg = busy != 0 ? 3'(3'b001 << owner) : 3'b000;
            er = eg & {3{(exp_q.size() == 0) || pr_s}};
            #1;
            check("rnd grant", grant, eg);
            check("rnd ready", req_ready, er);
            if (exp_q.size() > 0) begin
                check("rnd pw", pixelWrite, 1'b1);
                check("rnd x", xAddr, exp_q[0].x);
                check("rnd y", yAddr, exp_q[0].y);
                check("rnd data", pixelData, exp_q[0].d);
                if (pr_s) void'(exp_q.pop_front());
            end else begin
                check("rnd pw idle", pixelWrite, 1'b0);
            end
            if (busy != 0) begin
                if (v_s[owner] && er[owner]) begin
                    px = src_q[owner].pop_front();
                    if (px.x < 8'd240 && px.y < 9'd320) exp_q.push_back(px);
                    else exp_drops++;
                    if (px.l) busy = 0;
                end
            end else if (v_s != 3'b000) begin
                owner = pick(v_s, mptr);
                mptr = owner;
                busy = 1;
            end
            next_cycle();
            cyc++;
        end
        #1;
        check("rnd completion", (cyc < 3000), 1'b1);
        check("rnd drop", drop_count, 16'(exp_drops));
        check("rnd abort", abort_count, 8'd0);
        check("rnd final pw", pixelWrite, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lt24_pixel_arbiter.md
# lt24_pixel_arbiter

Shares the single LT24Display pixel-write port between several pixel producers: maze background renderer, player sprite drawer, overlay. Each producer streams pixel bursts (x, y, RGB565) with a valid/ready handshake. The arbiter grants one burst at a time, registers the selected pixel into the display's xAddr/yAddr/pixelData/pixelWrite inputs, and discards off-screen pixels. It sits between the game renderers and LT24Display, replacing the free-running x/y counters.

## Interface
- NUM_REQ, 3, number of requesters (2..8); index 0 = maze, 1 = sprite, 2 = overlay
- WIDTH, 240, display width in pixels
- HEIGHT, 320, display height in pixels
- STALL_TIMEOUT, 1023, cycles a granted requester may hold req_valid low mid-burst before the grant is revoked; 0 disables the timeout
- clock  in  1  system clock, 50 MHz
- resetApp  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  pixel offered by requester i
- req_last  in  NUM_REQ  offered pixel is the last of its burst
- req_x  in  8*NUM_REQ  x coordinate, slice i = [8i+7:8i]
- req_y  in  9*NUM_REQ  y coordinate, slice i = [9i+8:9i]
- req_data  in  16*NUM_REQ  RGB565 colour
- req_ready  out  NUM_REQ  pixel from requester i accepted this cycle when high with req_valid
- grant  out  NUM_REQ  one-hot registered grant
- xAddr  out  8  to LT24Display
- yAddr  out  9  to LT24Display
- pixelData  out  16  to LT24Display
- pixelWrite  out  1  output register holds a pixel
- pixelReady  in  1  LT24Display accepts pixel when high with pixelWrite
- drop_count  out  16  saturating count of discarded off-screen pixels
- abort_count  out  8  saturating count of timeout-revoked grants

## Operation
- FSM states: IDLE, BURST.
- IDLE: if any req_valid is high, pick a winner, set grant one-hot, go to BURST. Otherwise stay in IDLE with grant = 0.
- Fixed-priority pick: lowest index wins.
- BURST: req_ready[i] = grant[i] && (!pixelWrite || pixelReady). This is combinational from pixelReady.
- Transfer = req_valid[i] && req_ready[i].
- On a transfer with the pixel on screen (x < WIDTH and y < HEIGHT): load xAddr/yAddr/pixelData and set pixelWrite.
- On a transfer with the pixel off screen: the pixel is consumed. The output register is left unchanged, except that pixelWrite clears if pixelReady consumed the previous pixel. drop_count increments.
- On a display consume with no new transfer: pixelWrite clears.
- On a transfer with req_last: clear grant and return to IDLE.
- Stall counter: counts consecutive BURST cycles with req_valid[granted] low; resets on any transfer. When it reaches STALL_TIMEOUT (nonzero), clear grant, return to IDLE, increment abort_count. A pixel already in the output register still drains.
- Non-granted requesters always see req_ready = 0.
- Counters saturate at all-ones.

## Timing
- Reset values: state IDLE, grant 0, req_ready 0, pixelWrite 0, xAddr 0, yAddr 0, pixelData 0, drop_count 0, abort_count 0, round-robin pointer NUM_REQ-1.
- Grant latency: req_valid seen in IDLE at cycle n; grant high at n+1; first transfer at n+1; pixelWrite high at n+2.
- Throughput: one pixel per cycle while pixelReady stays high.
- A req_last transfer at cycle n drops grant at n+1 (IDLE). The earliest next grant is n+2, giving one dead arbitration cycle per burst.
- If pixelReady is low with pixelWrite high, all outputs hold and req_ready = 0.
- Simultaneous display consume and new transfer: the register reloads and pixelWrite stays high.
- req_valid dropped by a non-granted requester in IDLE: not latched.
- resetApp asserted mid-burst clears pixelWrite and grant immediately (asynchronous). The in-flight pixel is lost.

## Configuration
- ARB_ROUND_ROBIN_EN defined: the IDLE pick starts searching at index (pointer+1) mod NUM_REQ. The pointer updates to the winner on each grant.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, lowest index wins, and the pointer register is not built.

## Structure
- Package lt24_arb_pkg holds:
  - state enum (IDLE, BURST)
  - LT24_X_W = 8, LT24_Y_W = 9, LT24_PIX_W = 16
  - saturating-increment function.
- Sub-module lt24_arb_picker: combinational one-hot winner from the request vector and pointer. Under ARB_ROUND_ROBIN_EN it rotates the vector; otherwise it is a priority encoder.

## Test plan
- Single burst: req0 sends 4 pixels (x = 0..3, y = 5, data = 16'h07E0, last on the 4th), pixelReady held high. Required: grant = 3'b001 one cycle after valid, four pixelWrite cycles with matching x/data, grant = 0 after last.
- Contention: req0 and req2 valid together in IDLE. Fixed priority: req0 is served first, req2 only after req0's last. With ARB_ROUND_ROBIN_EN and three back-to-back one-pixel bursts on each: grant order 0, 2, 0, 2.
- Backpressure: pixelReady low for 5 cycles mid-burst. Required: xAddr/pixelData stable, req_ready = 0, no pixel lost or duplicated.
- Clipping: pixels x = 240, y = 10 and x = 3, y = 320. Required: both consumed, pixelWrite never shows them, drop_count = 2.
- Timeout: with STALL_TIMEOUT = 8, req1 granted sends 1 pixel, then holds valid low. Required: grant revoked exactly 8 cycles after the transfer, abort_count = 1, the pending pixel still written.
- Reset mid-burst: assert resetApp during a req0 burst. Required: grant, pixelWrite and counters at 0 in the same cycle; the next request is arbitrated normally.
